// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: absorbs core write bursts and presents
// a show-ahead head byte on the transmitter's wr/data/busy handshake.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          tx_wr,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        push       = wr_en && !full_q;
        pop        = !empty_q && !tx_busy;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);

        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);

        // A dropped push in the same cycle as a clear leaves the flag set.
        if (ovf_clr)         overflow_d = 1'b0;
        if (wr_en && full_q) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_wr    = !empty_q;
    assign tx_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed pushes queue expected bytes, a
// transmitter model (CLOCKS_PER_BAUD=4, 10-bit frame) pops and compares accepted bytes.
module tb_uart_tx_fifo;

    localparam int DEPTH      = 16;
    localparam int FRAME_CLKS = 4 * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       hold_busy = 1'b0;
    logic       full, empty, overflow, tx_wr, tx_busy;
    logic [4:0] count;
    logic [7:0] tx_data;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int         busy_cnt = 0;
    bit         accept_pend = 1'b0;
    int         tx_sent = 0;
    int         checks = 0;
    int         failures = 0;
    int         sent_before;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = hold_busy || (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit exp_accept);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (exp_accept) exp_q.push_back(b);
    endtask

    task automatic wait_tx_idle(input int limit);
        for (int n = 0; n < limit && busy_cnt != 0; n++) tick();
        check("tx_idle_timeout", busy_cnt, 0);
    endtask

    task automatic wait_drain(input int limit);
        for (int n = 0; n < limit && !(exp_q.size() == 0 && empty && busy_cnt == 0); n++) tick();
        check("drain_timeout", {exp_q.size() == 0, empty, busy_cnt == 0}, 3'b111);
    endtask

    // Transmitter model / monitor: an accept is decided just before the edge it happens on.
    always @(negedge clk) begin
        accept_pend = (tx_wr === 1'b1) && (tx_busy === 1'b0);
        if (accept_pend) begin
            tx_sent++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got %02h required no byte", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", tx_data, mon_exp);
            end
        end
    end

    always @(posedge clk) begin
        if (accept_pend)        busy_cnt <= FRAME_CLKS;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle.
        tick();
        tick();
        rst = 1'b0;
        check("rst_flags", {empty, full, tx_wr, overflow}, 4'b1000);
        check("rst_count", count, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", {empty, tx_wr, count}, {1'b1, 1'b0, 5'd0});
        end
        check("idle_no_tx", tx_sent, 0);

        // Single byte latency: visible after the push edge, popped on the next edge.
        push(8'h41, 1'b1);
        check("lat_tx_wr", tx_wr, 1);
        check("lat_tx_data", tx_data, 8'h41);
        check("lat_count", count, 1);
        tick();
        check("lat_popped", {empty, tx_wr, count}, {1'b1, 1'b0, 5'd0});
        wait_drain(100);

        // Fill while busy, overflow on the 17th push, then drain in order.
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b1);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        push(8'hAA, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        hold_busy = 1'b0;
        wait_drain(DEPTH * (FRAME_CLKS + 2) + 50);
        check("drain_empty", empty, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Full: set wins over clear; push dropped during a pop; next push lands last.
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i), 1'b1);
        wr_en = 1'b1; wr_data = 8'hBB; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("popfull_count", count, 15);
        check("popfull_flags", {full, overflow}, 2'b01);
        push(8'h55, 1'b1);
        check("refill_count", count, 16);
        wait_drain(DEPTH * (FRAME_CLKS + 2) + 50);

        // Count 5, simultaneous push and pop, repeated across the pointer wrap.
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b1);
        check("c5_count", count, 5);
        for (int k = 0; k < 12; k++) begin
            wait_tx_idle(FRAME_CLKS + 10);
            hold_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h80 + 8'(k);
            tick();
            hold_busy = 1'b1; wr_en = 1'b0;
            exp_q.push_back(8'h80 + 8'(k));
            check("c5_pushpop", count, 5);
        end
        hold_busy = 1'b0;
        wait_drain(8 * (FRAME_CLKS + 2) + 50);

        // Reset with 7 queued while the transmitter is mid-byte.
        push(8'h90, 1'b1);
        tick();
        hold_busy = 1'b1;
        for (int i = 1; i <= 7; i++) push(8'h90 + 8'(i), 1'b1);
        check("pre_rst_count", count, 7);
        check("pre_rst_midbyte", busy_cnt != 0, 1);
        sent_before = tx_sent;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("rst2_flags", {empty, tx_wr, overflow, full}, 4'b1000);
        check("rst2_count", count, 0);
        hold_busy = 1'b0;
        wait_tx_idle(FRAME_CLKS + 10);
        for (int i = 0; i < 10; i++) tick();
        check("rst2_no_more_tx", tx_sent, sent_before);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
